logic_arbiter: RTL and testbench
================================

Name: logic_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the shared combinational logic unit (Logic, AND/OR/XOR/NOT with Z/N/P flags).
- Accepts one operation at a time over valid/ready, registers operands, executes, and holds the registered result and flags on a valid/ready response channel tagged with the requester ID.
- Sits between the register-file/issue stage and writeback.

Parameters:
- Width, 16, operand and result width; passed through to the Logic instance.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_a  input  Width  operand A, requester 0.
- req0_b  input  Width  operand B, requester 0.
- req0_f  input  3  function code, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_f  same as above, requester 1.
- rsp_valid  output  1  result registers hold a completed operation.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester that issued the result.
- rsp_out  output  Width  result.
- rsp_z, rsp_n, rsp_p  output  1 each  zero, negative and even-parity flags from Logic.
- rsp_err  output  1  function code was 1xx (unsupported); result and flags are 0.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, last_grant = 1, so requester 0 wins the first tie.
  - All operand, ID and result registers = 0.
  - rsp_valid = 0.
  - req0_ready = req1_ready = 0 while rst is high.
- States:
  - IDLE:
    - req*_ready is combinationally high only for the granted requester.
    - Grant rule: only one valid requester wins; if both are valid, the one not equal to last_grant wins.
    - On accept (valid && ready): latch a, b, f and ID, set last_grant = ID, go to EXEC.
    - With no valid requester, stay in IDLE.
  - EXEC:
    - Logic sees the latched operands. At the clock edge, register Out/Z/N/P into the rsp_* registers and set rsp_err = f[2]. Go to HOLD.
    - Both req*_ready = 0.
  - HOLD:
    - rsp_valid = 1; all rsp_* outputs are stable until the handshake.
    - On rsp_ready go to IDLE and clear rsp_valid. Otherwise stay in HOLD.
    - Both req*_ready = 0.
- Latency: accept at edge t; rsp_valid is high from cycle t+2. With rsp_ready tied high, the throughput is one operation per 3 cycles.
- Requester obligations: requesters hold valid and operands until accepted. The arbiter never drops an accepted operation.
- Fairness: a requester that stays valid is served within 2 grants.
- Grant changes: a grant may change between cycles in IDLE, since no grant is committed before the handshake.
- Unsupported f (100–111): executed normally. Logic returns Out=0, Z=N=P=0; rsp_err=1.
- Reset mid-operation (EXEC or HOLD): the operation is discarded, rsp_valid drops immediately (asynchronous), and the block returns to IDLE with last_grant = 1.
- Backpressure: rsp_ready high while rsp_valid is low has no effect.

Decomposition:
- Shared package holds:
  - function-code constants: F_AND=3'b000, F_OR=3'b001, F_XOR=3'b010, F_NOT=3'b011.
  - state encoding: ST_IDLE=2'd0, ST_EXEC=2'd1, ST_HOLD=2'd2.
- One sub-module: the existing Logic, instantiated once with Width passed through.
- Grant logic stays inline; no separate arbiter module.

Test Plan:
- Reset, then req0 only with A=16'h00F0, B=16'h0FF0, f=000 → req0_ready in the first cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_out=16'h00F0, Z=0, N=0, P=1, err=0.
- Both valid right after reset:
  - req0 = (16'hFFFF, 16'h0000, f=001); req1 = (16'h8000, –, f=011).
  - Expected order: req0 first (rsp_out=16'hFFFF, N=1, P=1), then req1 (rsp_out=16'h7FFF, N=0, P=0).
  - Then a third request from both again is granted to req0 again, since last_grant=1.
- Hold rsp_ready=0 for 5 cycles after rsp_valid with XOR of 16'hAAAA and 16'hAAAA → rsp_out=0, Z=1, P=1 stay stable; both req*_ready stay 0; the operation completes on the cycle rsp_ready rises.
- f=3'b110 from req1 → rsp_err=1, rsp_out=0, Z=N=P=0, rsp_id=1.
- Assert rst during HOLD → rsp_valid=0 asynchronously; after release the next tie is granted to req0.
- Both requesters continuously valid for 10 operations with rsp_ready=1 → grants strictly alternate 0,1,0,1…; one operation completes every 3 cycles.

Source files
------------

// File: rtl/logic_arbiter_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter.
// Function codes, sequencer state encoding and operand-width defaults.
package logic_arbiter_pkg;

    localparam int unsigned FUNC_W      = 3;
    localparam int unsigned DEF_WIDTH   = 16;

    localparam logic [FUNC_W-1:0] F_AND = 3'b000;
    localparam logic [FUNC_W-1:0] F_OR  = 3'b001;
    localparam logic [FUNC_W-1:0] F_XOR = 3'b010;
    localparam logic [FUNC_W-1:0] F_NOT = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Codes 1xx are outside the supported set.
    function automatic logic is_unsupported(input logic [FUNC_W-1:0] f);
        return f[FUNC_W-1];
    endfunction

endpackage

// File: rtl/logic_arbiter_logic.sv
// Shared combinational logic unit: AND/OR/XOR/NOT with zero, negative
// and even-parity flags. Unsupported codes yield zero result and flags.
module logic_arbiter_logic
    import logic_arbiter_pkg::*;
#(
    parameter int unsigned Width = DEF_WIDTH
) (
    input  logic [Width-1:0]  a,
    input  logic [Width-1:0]  b,
    input  logic [FUNC_W-1:0] f,
    output logic [Width-1:0]  out_c,
    output logic              z_c,
    output logic              n_c,
    output logic              p_c
);

    always_comb begin
        out_c = '0;
        z_c   = 1'b0;
        n_c   = 1'b0;
        p_c   = 1'b0;
        case (f)
            F_AND:   out_c = a & b;
            F_OR:    out_c = a | b;
            F_XOR:   out_c = a ^ b;
            F_NOT:   out_c = ~a;
            default: out_c = '0;
        endcase
        // Flags are forced low for unsupported codes, including the zero flag.
        if (!is_unsupported(f)) begin
            z_c = (out_c == '0);
            n_c = out_c[Width-1];
            p_c = ~(^out_c);
        end
    end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared logic unit:
// accept one request, execute it, hold the tagged result until consumed.
module logic_arbiter
    import logic_arbiter_pkg::*;
#(
    parameter int unsigned Width = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [Width-1:0]    req0_a,
    input  logic [Width-1:0]    req0_b,
    input  logic [FUNC_W-1:0]   req0_f,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [Width-1:0]    req1_a,
    input  logic [Width-1:0]    req1_b,
    input  logic [FUNC_W-1:0]   req1_f,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [Width-1:0]    rsp_out,
    output logic                rsp_z,
    output logic                rsp_n,
    output logic                rsp_p,
    output logic                rsp_err
);

    state_e              state_q,      state_d;
    logic                last_grant_q, last_grant_d;
    logic [Width-1:0]    a_q,          a_d;
    logic [Width-1:0]    b_q,          b_d;
    logic [FUNC_W-1:0]   f_q,          f_d;
    logic                id_q,         id_d;
    logic                rsp_valid_q,  rsp_valid_d;
    logic                rsp_id_q,     rsp_id_d;
    logic [Width-1:0]    rsp_out_q,    rsp_out_d;
    logic                rsp_z_q,      rsp_z_d;
    logic                rsp_n_q,      rsp_n_d;
    logic                rsp_p_q,      rsp_p_d;
    logic                rsp_err_q,    rsp_err_d;

    logic                grant_vld_c;
    logic                grant_id_c;
    logic [Width-1:0]    lu_out_c;
    logic                lu_z_c;
    logic                lu_n_c;
    logic                lu_p_c;

    logic_arbiter_logic #(
        .Width (Width)
    ) u_logic (
        .a     (a_q),
        .b     (b_q),
        .f     (f_q),
        .out_c (lu_out_c),
        .z_c   (lu_z_c),
        .n_c   (lu_n_c),
        .p_c   (lu_p_c)
    );

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_vld_c = req0_valid | req1_valid;
        grant_id_c  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id_c = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id_c = 1'b1;
        end
    end

    assign req0_ready = !rst && (state_q == ST_IDLE) && req0_valid && !grant_id_c;
    assign req1_ready = !rst && (state_q == ST_IDLE) && req1_valid &&  grant_id_c;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        f_d          = f_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        rsp_z_d      = rsp_z_q;
        rsp_n_d      = rsp_n_q;
        rsp_p_d      = rsp_p_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld_c) begin
                    a_d          = grant_id_c ? req1_a : req0_a;
                    b_d          = grant_id_c ? req1_b : req0_b;
                    f_d          = grant_id_c ? req1_f : req0_f;
                    id_d         = grant_id_c;
                    last_grant_d = grant_id_c;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_out_d   = lu_out_c;
                rsp_z_d     = lu_z_c;
                rsp_n_d     = lu_n_c;
                rsp_p_d     = lu_p_c;
                rsp_err_d   = is_unsupported(f_q);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            f_q          <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_z_q      <= 1'b0;
            rsp_n_q      <= 1'b0;
            rsp_p_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            f_q          <= f_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            rsp_z_q      <= rsp_z_d;
            rsp_n_q      <= rsp_n_d;
            rsp_p_q      <= rsp_p_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_n     = rsp_n_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_logic_arbiter.sv
// Self-checking bench for logic_arbiter: vector table, scoreboard of
// expected responses, and directed multi-cycle corner cases.
module tb_logic_arbiter;
    import logic_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_a, req0_b;
    logic [2:0]  req0_f;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_a, req1_b;
    logic [2:0]  req1_f;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_out;
    logic        rsp_z, rsp_n, rsp_p, rsp_err;

    logic_arbiter #(.Width(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_f     (req0_f),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_f     (req1_f),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out),
        .rsp_z      (rsp_z),
        .rsp_n      (rsp_n),
        .rsp_p      (rsp_p),
        .rsp_err    (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  f;
        logic [15:0] out;
        logic        z, n, p, err;
    } op_t;

    typedef struct {
        logic        id;
        logic [15:0] out;
        logic        z, n, p, err;
    } exp_t;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  f;
        logic [15:0] out;
        logic        z, n, p, err;
    } vec_t;

    op_t   q0[$];
    op_t   q1[$];
    op_t   cur0, cur1;
    exp_t  sb[$];
    logic  grants[$];
    int    rsp_cyc[$];
    int    cyc;
    int    n_cmp;
    int    n_fail;
    vec_t  vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f,
                               input logic [15:0] out, input logic z, input logic n,
                               input logic p, input logic err);
        op_t o;
        o.a = a; o.b = b; o.f = f; o.out = out;
        o.z = z; o.n = n; o.p = p; o.err = err;
        return o;
    endfunction

    // Reference model of the logic unit.
    function automatic op_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
        op_t o;
        o.a = a; o.b = b; o.f = f;
        o.z = 1'b0; o.n = 1'b0; o.p = 1'b0; o.err = 1'b0;
        case (f)
            3'd0:    o.out = a & b;
            3'd1:    o.out = a | b;
            3'd2:    o.out = a ^ b;
            3'd3:    o.out = ~a;
            default: o.out = 16'h0000;
        endcase
        if (f >= 3'd4) begin
            o.err = 1'b1;
        end else begin
            o.z = (o.out == 16'h0000);
            o.n = (o.out >= 16'h8000);
            o.p = (($countones(o.out) % 2) == 0);
        end
        return o;
    endfunction

    task automatic refill();
        if (!req0_valid && q0.size() > 0) begin
            cur0 = q0.pop_front();
            req0_valid = 1'b1; req0_a = cur0.a; req0_b = cur0.b; req0_f = cur0.f;
        end
        if (!req1_valid && q1.size() > 0) begin
            cur1 = q1.pop_front();
            req1_valid = 1'b1; req1_a = cur1.a; req1_b = cur1.b; req1_f = cur1.f;
        end
    endtask

    // One clock: observe handshakes at negedge, update drivers after posedge.
    task automatic cycle();
        logic acc0, acc1;
        exp_t e;
        @(negedge clk);
        cyc++;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0 || acc1) check("single_grant", 32'(acc0 && acc1), 0);
        if (acc0) begin
            e.id = 1'b0; e.out = cur0.out; e.z = cur0.z; e.n = cur0.n; e.p = cur0.p; e.err = cur0.err;
            sb.push_back(e);
            grants.push_back(1'b0);
        end
        if (acc1) begin
            e.id = 1'b1; e.out = cur1.out; e.z = cur1.z; e.n = cur1.n; e.p = cur1.p; e.err = cur1.err;
            sb.push_back(e);
            grants.push_back(1'b1);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_empty: unexpected response id=%0d out=%0h", rsp_id, rsp_out);
            end else begin
                e = sb.pop_front();
                check("rsp_id",  32'(rsp_id),  32'(e.id));
                check("rsp_out", 32'(rsp_out), 32'(e.out));
                check("rsp_z",   32'(rsp_z),   32'(e.z));
                check("rsp_n",   32'(rsp_n),   32'(e.n));
                check("rsp_p",   32'(rsp_p),   32'(e.p));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            rsp_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        refill();
    endtask

    function automatic bit is_idle();
        return (q0.size() == 0) && (q1.size() == 0) && !req0_valid && !req1_valid &&
               (sb.size() == 0) && !rsp_valid;
    endfunction

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (is_idle()) break;
            cycle();
        end
        check("drain_done", 32'(is_idle()), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        q0.delete(); q1.delete(); sb.delete(); grants.delete(); rsp_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic exp_g[4];
        op_t  o;
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_f = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_f = '0;
        rsp_ready = 1'b1;
        n_cmp = 0; n_fail = 0; cyc = 0;

        vecs[0] = '{1'b0, 16'h00F0, 16'h0FF0, F_AND,  16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 16'h00F0, 16'h0FF0, F_OR,   16'h0FF0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'hAAAA, 16'h5555, F_XOR,  16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h0000, F_NOT,  16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h1234, 16'h5678, 3'b110, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 16'hFFFF, F_AND,  16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h0001, 16'h0000, F_OR,   16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'hFFFF, 16'hFFFF, 3'b111, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 16'hFFFF, 16'h1234, F_NOT,  16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state, with requests asserted while rst is high.
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_ready0",    32'(req0_ready), 0);
        check("rst_ready1",    32'(req1_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid),  0);
        check("rst_rsp_out",   32'(rsp_out),    0);
        check("rst_rsp_id",    32'(rsp_id),     0);
        check("rst_rsp_err",   32'(rsp_err),    0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request: ready in first cycle, response two cycles later.
        q0.push_back(mk(16'h00F0, 16'h0FF0, F_AND, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0));
        refill();
        #1;
        check("t1_ready_first", 32'(req0_ready), 1);
        check("t1_ready1_low",  32'(req1_ready), 0);
        cycle();
        check("t1_exec_no_valid", 32'(rsp_valid), 0);
        check("t1_exec_ready0",   32'(req0_ready), 0);
        cycle();
        check("t1_valid",  32'(rsp_valid), 1);
        check("t1_rsp_id", 32'(rsp_id),    0);
        drain(10);

        // Table-driven vectors, one at a time.
        for (int i = 0; i < 9; i++) begin
            o = mk(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].out, vecs[i].z, vecs[i].n, vecs[i].p, vecs[i].err);
            if (vecs[i].id) q1.push_back(o);
            else            q0.push_back(o);
            refill();
            drain(20);
        end

        // Tie right after reset, then another tie.
        do_reset();
        q0.push_back(mk(16'hFFFF, 16'h0000, F_OR,  16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0));
        q1.push_back(mk(16'h8000, 16'h0000, F_NOT, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0));
        refill();
        drain(20);
        q0.push_back(model(16'h0F0F, 16'h00FF, F_AND));
        q1.push_back(model(16'h0001, 16'h0001, F_XOR));
        refill();
        drain(20);
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
        check("t2_grant_count", 32'(grants.size()), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("t2_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));

        // Backpressure: result held stable, requesters blocked.
        rsp_ready = 1'b0;
        q0.push_back(mk(16'hAAAA, 16'hAAAA, F_XOR, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
        refill();
        for (int i = 0; i < 10 && !rsp_valid; i++) cycle();
        check("t3_valid", 32'(rsp_valid), 1);
        q1.push_back(model(16'h1234, 16'h00FF, F_AND));
        refill();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_hold_valid", 32'(rsp_valid),  1);
            check("t3_hold_out",   32'(rsp_out),    0);
            check("t3_hold_z",     32'(rsp_z),      1);
            check("t3_hold_p",     32'(rsp_p),      1);
            check("t3_hold_rdy0",  32'(req0_ready), 0);
            check("t3_hold_rdy1",  32'(req1_ready), 0);
        end
        rsp_ready = 1'b1;
        cycle();
        check("t3_released", 32'(rsp_valid), 0);
        drain(20);

        // Reset during HOLD drops the response at once; next tie goes to req0.
        rsp_ready = 1'b0;
        q1.push_back(model(16'h00FF, 16'h0F0F, F_OR));
        refill();
        for (int i = 0; i < 10 && !rsp_valid; i++) cycle();
        check("t5_valid", 32'(rsp_valid), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_drop", 32'(rsp_valid), 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t5_rst_rdy0", 32'(req0_ready), 0);
        check("t5_rst_rdy1", 32'(req1_ready), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        q0.delete(); q1.delete(); sb.delete(); grants.delete(); rsp_cyc.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        q0.push_back(model(16'h0F0F, 16'hFFFF, F_XOR));
        q1.push_back(model(16'h3333, 16'h0000, F_NOT));
        refill();
        #1;
        check("t5_tie_rdy0", 32'(req0_ready), 1);
        check("t5_tie_rdy1", 32'(req1_ready), 0);
        drain(20);

        // Both continuously valid: strict alternation, one result per 3 cycles.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q0.push_back(model(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7))));
            q1.push_back(model(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7))));
        end
        refill();
        drain(60);
        check("t6_grant_count", 32'(grants.size()), 10);
        for (int i = 0; i < grants.size(); i++)
            check($sformatf("t6_grant%0d", i), 32'(grants[i]), 32'(i % 2));
        check("t6_rsp_count", 32'(rsp_cyc.size()), 10);
        for (int i = 1; i < rsp_cyc.size(); i++)
            check($sformatf("t6_spacing%0d", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
